// File: rtl/cga_pkg.sv
// Shared definitions for the CGA text console writer: screen geometry,
// store address width, control-code values and the writer state set.
package cga_pkg;

  localparam int CGA_COLS   = 80;
  localparam int CGA_ROWS   = 25;
  localparam int CGA_MEM_AW = 13;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] FF  = 8'h0C;
  localparam logic [7:0] TAB = 8'h09;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUT_CH,
    ST_PUT_AT,
    ST_CTRL,
    ST_NL,
    ST_SC_RD,
    ST_SC_WAIT,
    ST_SC_WR,
    ST_FILL
  } cga_state_e;

endpackage

// File: rtl/cga_fill_seq.sv
// Range fill sequencer: once loaded with a start address it walks up to the
// end address one byte per enabled cycle, producing blank (0x20) on even
// addresses and the supplied attribute on odd ones.
module cga_fill_seq
  import cga_pkg::*;
#(
  parameter int AW = CGA_MEM_AW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [AW-1:0] i_startAddr,
  input  logic [AW-1:0] i_endAddr,
  input  logic [7:0]    i_attr,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_data,
  output logic          o_we,
  output logic          o_last
);

  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_endAddr;

  // Load the range on i_load, otherwise step the address while enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr    <= '0;
      r_endAddr <= '0;
    end else if (i_load) begin
      r_addr    <= i_startAddr;
      r_endAddr <= i_endAddr;
    end else if (i_en && (r_addr != r_endAddr)) begin
      r_addr <= r_addr + AW'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_data = r_addr[0] ? i_attr : 8'h20;
  assign o_we   = i_en;
  assign o_last = (r_addr == r_endAddr);

endmodule

// File: rtl/cga_console.sv
// CGA console writer: turns a byte stream into char/attribute writes on the
// text store, tracking the cursor, wrapping lines and scrolling by copying
// rows up one at a time through the store's read port.
// Optional feature macro: CGA_CONSOLE_TAB_EN enables 0x09 tab stops every
// 8 columns; without it 0x09 is ignored like other control codes.
module cga_console
  import cga_pkg::*;
#(
  parameter int COLS       = CGA_COLS,
  parameter int ROWS       = CGA_ROWS,
  parameter int RD_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  attr,
  output logic [12:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_q,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam int ROW_BYTES    = 2 * COLS;
  localparam int SCREEN_BYTES = 2 * COLS * ROWS;
  localparam int SCROLL_BYTES = 2 * COLS * (ROWS - 1);
  localparam int WAIT_W       = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  cga_state_e         r_state;
  logic [6:0]         r_x;
  logic [4:0]         r_y;
  logic [7:0]         r_char;
  logic [7:0]         r_attr;
  logic [12:0]        r_memAddr;
  logic [7:0]         r_memWdata;
  logic [12:0]        r_idx;
  logic [WAIT_W-1:0]  r_waitCnt;
  logic               r_homeAfterFill;

  logic [12:0]        w_rowBase;
  logic [12:0]        w_cellIdx;
  logic [12:0]        w_cellAddr;
  logic               w_fillLoad;
  logic [12:0]        w_fillStart;
  logic [12:0]        w_fillAddr;
  logic [7:0]         w_fillData;
  logic               w_fillWe;
  logic               w_fillLast;
  logic               w_fillEn;
`ifdef CGA_CONSOLE_TAB_EN
  logic [7:0]         w_tabX;
  assign w_tabX = {1'b0, r_x[6:3], 3'b000} + 8'd8;
`endif

  // Byte address of the cursor cell; the row multiply stays combinational.
  assign w_rowBase  = 13'(r_y) * 13'(COLS);
  assign w_cellIdx  = w_rowBase + 13'(r_x);
  assign w_cellAddr = {w_cellIdx[11:0], 1'b0};

  assign w_fillEn = (r_state == ST_FILL);

  // Arm the fill sequencer on the cycle before FILL: whole screen for FF,
  // last row only when the scroll copy finishes.
  always_comb begin
    w_fillLoad  = 1'b0;
    w_fillStart = '0;
    if ((r_state == ST_CTRL) && (r_char == FF)) begin
      w_fillLoad  = 1'b1;
      w_fillStart = '0;
    end else if ((r_state == ST_SC_WR) && (r_idx == 13'(SCROLL_BYTES - 1))) begin
      w_fillLoad  = 1'b1;
      w_fillStart = 13'(SCROLL_BYTES);
    end
  end

  cga_fill_seq #(
    .AW(13)
  ) u_fill (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_load      (w_fillLoad),
    .i_en        (w_fillEn),
    .i_startAddr (w_fillStart),
    .i_endAddr   (13'(SCREEN_BYTES - 1)),
    .i_attr      (r_attr),
    .o_addr      (w_fillAddr),
    .o_data      (w_fillData),
    .o_we        (w_fillWe),
    .o_last      (w_fillLast)
  );

  // Writer FSM: accept, dispatch, put char/attr, newline, scroll copy, fill.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_x             <= '0;
      r_y             <= '0;
      r_char          <= '0;
      r_attr          <= '0;
      r_memAddr       <= '0;
      r_memWdata      <= '0;
      r_idx           <= '0;
      r_waitCnt       <= '0;
      r_homeAfterFill <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_char <= in_data;
            r_attr <= attr;
            if (in_data >= 8'h20) begin
              r_memAddr  <= w_cellAddr;
              r_memWdata <= in_data;
              r_state    <= ST_PUT_CH;
            end else begin
              r_state <= ST_CTRL;
            end
          end
        end
        ST_PUT_CH: begin
          r_memAddr  <= r_memAddr + 13'd1;
          r_memWdata <= r_attr;
          r_state    <= ST_PUT_AT;
        end
        ST_PUT_AT: begin
          if (r_x < 7'(COLS - 1)) begin
            r_x     <= r_x + 7'd1;
            r_state <= ST_IDLE;
          end else begin
            r_x     <= '0;
            r_state <= ST_NL;
          end
        end
        ST_CTRL: begin
          r_state <= ST_IDLE;
          case (r_char)
            CR: r_x <= '0;
            LF: r_state <= ST_NL;
            BS: begin
              if (r_x != 7'd0) r_x <= r_x - 7'd1;
            end
            FF: begin
              r_homeAfterFill <= 1'b1;
              r_state         <= ST_FILL;
            end
`ifdef CGA_CONSOLE_TAB_EN
            TAB: begin
              if (w_tabX >= 8'(COLS)) begin
                r_x     <= '0;
                r_state <= ST_NL;
              end else begin
                r_x <= w_tabX[6:0];
              end
            end
`endif
            default: ;
          endcase
        end
        ST_NL: begin
          if (r_y < 5'(ROWS - 1)) begin
            r_y     <= r_y + 5'd1;
            r_state <= ST_IDLE;
          end else begin
            r_idx     <= '0;
            r_waitCnt <= '0;
            r_memAddr <= 13'(ROW_BYTES);
            r_state   <= ST_SC_RD;
          end
        end
        ST_SC_RD: begin
          r_waitCnt <= '0;
          r_state   <= ST_SC_WAIT;
        end
        ST_SC_WAIT: begin
          if (r_waitCnt == WAIT_W'(RD_LATENCY - 1)) begin
            r_memWdata <= mem_q;
            r_memAddr  <= r_idx;
            r_state    <= ST_SC_WR;
          end else begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
          end
        end
        ST_SC_WR: begin
          if (r_idx == 13'(SCROLL_BYTES - 1)) begin
            r_homeAfterFill <= 1'b0;
            r_state         <= ST_FILL;
          end else begin
            r_idx     <= r_idx + 13'd1;
            r_memAddr <= r_idx + 13'(ROW_BYTES + 1);
            r_state   <= ST_SC_RD;
          end
        end
        ST_FILL: begin
          if (w_fillLast) begin
            if (r_homeAfterFill) begin
              r_x <= '0;
              r_y <= '0;
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_we = (r_state == ST_PUT_CH) || (r_state == ST_PUT_AT) ||
                  (r_state == ST_SC_WR) || w_fillWe;
  assign mem_address = w_fillEn ? w_fillAddr : r_memAddr;
  assign mem_wdata   = w_fillEn ? w_fillData : r_memWdata;
  assign in_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign cursor_x    = r_x;
  assign cursor_y    = r_y;

endmodule

// File: tb/tb_cga_console.sv
// Randomised scoreboard bench for cga_console. A screen-level reference
// model predicts every store write and the cursor; a monitor checks writes
// as they appear on the store port. Honours CGA_CONSOLE_TAB_EN like the DUT.
module tb_cga_console;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  attr = 8'h00;
  logic [12:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_q = 8'h00;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t  expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   writeCount = 0;
  int   lastWriteAddr = -1;
  int   modelMem[4000];
  int   modelX = 0;
  int   modelY = 0;
  logic [7:0] ram [0:8191];

  cga_console dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .attr        (attr),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_q       (mem_q),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .busy        (busy)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Text store port B: synchronous write, one-cycle read latency.
  always @(posedge clock) begin
    if (mem_we) ram[mem_address] <= mem_wdata;
    mem_q <= ram[mem_address];
  end

  // Monitor: every store write must be the next one the model predicted.
  always @(negedge clock) begin
    wr_t e;
    if (reset_n && mem_we) begin
      writeCount++;
      lastWriteAddr = int'(mem_address);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write addr=%0d data=%02h (no write expected)",
                 mem_address, mem_wdata);
      end else begin
        e = expQ.pop_front();
        if ((int'(mem_address) != e.addr) || (int'(mem_wdata) != e.data)) begin
          errors++;
          $display("[TB] FAIL mem_write got addr=%0d data=%02h expected addr=%0d data=%02h",
                   mem_address, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  // Safety net against a hung handshake.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic pushWrite(input int addr, input int data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
    if (addr < 4000) modelMem[addr] = data;
  endtask

  task automatic modelFill(input int first, input int a);
    for (int i = first; i < 4000; i++) pushWrite(i, (i % 2 == 0) ? 32 : a);
  endtask

  task automatic modelNewline(input int a);
    if (modelY < 24) begin
      modelY++;
    end else begin
      for (int i = 0; i < 3840; i++) pushWrite(i, modelMem[i + 160]);
      modelFill(3840, a);
    end
  endtask

  // Screen-level behaviour of one accepted byte.
  task automatic modelByte(input int c, input int a);
    int nx;
    if (c >= 32) begin
      pushWrite(2 * (modelY * 80 + modelX), c);
      pushWrite(2 * (modelY * 80 + modelX) + 1, a);
      if (modelX < 79) modelX++;
      else begin
        modelX = 0;
        modelNewline(a);
      end
    end else if (c == 13) begin
      modelX = 0;
    end else if (c == 10) begin
      modelNewline(a);
    end else if (c == 8) begin
      if (modelX > 0) modelX--;
    end else if (c == 12) begin
      modelFill(0, a);
      modelX = 0;
      modelY = 0;
    end
`ifdef CGA_CONSOLE_TAB_EN
    else if (c == 9) begin
      nx = (modelX / 8 + 1) * 8;
      if (nx >= 80) begin
        modelX = 0;
        modelNewline(a);
      end else begin
        modelX = nx;
      end
    end
`endif
    else begin
      nx = 0;
    end
  endtask

  // Send one byte, wait for the writer to return to idle, check the cursor.
  task automatic applyStimulus(input int c, input int a, output int lowCycles);
    int n;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 30000) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      checkOutput("ready_before_send_timeout", 0, 1);
    end
    modelByte(c, a);
    in_data  = 8'(c);
    attr     = 8'(a);
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    in_data   = 8'($urandom_range(0, 255));
    lowCycles = 0;
    n = 0;
    @(negedge clock);
    while (!in_ready && n < 30000) begin
      lowCycles++;
      n++;
      @(negedge clock);
    end
    if (!in_ready) checkOutput("idle_timeout", 0, 1);
    checkOutput("pending_writes", expQ.size(), 0);
    checkOutput("cursor_x", int'(cursor_x), modelX);
    checkOutput("cursor_y", int'(cursor_y), modelY);
  endtask

  task automatic compareRam(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 4000; i++) if (int'(ram[i]) != modelMem[i]) bad++;
    checkOutput(name, bad, 0);
  endtask

  function automatic int randomByte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80) return $urandom_range(32, 255);
    if (r < 85) return 13;
    if (r < 89) return 10;
    if (r < 93) return 8;
    if (r < 97) return 9;
    case ($urandom_range(0, 3))
      0: return 0;
      1: return 7;
      2: return 27;
      default: return 31;
    endcase
  endfunction

  initial begin
    int lc;
    int wc;
    for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
    for (int i = 0; i < 4000; i++) modelMem[i] = 0;

    // Reset values while reset is held.
    repeat (3) @(negedge clock);
    checkOutput("rst_mem_we", int'(mem_we), 0);
    checkOutput("rst_mem_address", int'(mem_address), 0);
    checkOutput("rst_mem_wdata", int'(mem_wdata), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_cursor_x", int'(cursor_x), 0);
    checkOutput("rst_cursor_y", int'(cursor_y), 0);
    reset_n = 1'b1;

    // 'A' with attr 0x1F: two writes, ready low for two cycles.
    applyStimulus(8'h41, 8'h1F, lc);
    checkOutput("put_ready_low_cycles", lc, 2);
    checkOutput("put_cursor_x", int'(cursor_x), 1);

    // Move to 5,3 then CR+LF must land at 0,4 without writes.
    applyStimulus(8'h0D, 8'h07, lc);
    for (int i = 0; i < 3; i++) applyStimulus(8'h0A, 8'h07, lc);
    for (int i = 0; i < 5; i++) applyStimulus($urandom_range(32, 126), 8'h07, lc);
    checkOutput("pos_5_3_x", int'(cursor_x), 5);
    wc = writeCount;
    applyStimulus(8'h0D, 8'h07, lc);
    applyStimulus(8'h0A, 8'h07, lc);
    checkOutput("crlf_cursor_y", int'(cursor_y), 4);
    checkOutput("crlf_no_writes", writeCount - wc, 0);

    // Form feed clears the screen with 0x20/0x07 and homes the cursor.
    wc = writeCount;
    applyStimulus(8'h0C, 8'h07, lc);
    checkOutput("ff_write_count", writeCount - wc, 4000);
    compareRam("ff_ram_image");

    // A full line of printables wraps to the next row.
    for (int i = 0; i < 80; i++) applyStimulus($urandom_range(32, 255), $urandom_range(0, 255), lc);
    checkOutput("line_last_addr", lastWriteAddr, 159);
    checkOutput("line_cursor_y", int'(cursor_y), 1);

    // Bottom-right printable writes then scrolls.
    for (int i = 0; i < 23; i++) applyStimulus(8'h0A, 8'h07, lc);
    for (int i = 0; i < 79; i++) applyStimulus($urandom_range(32, 255), 8'h07, lc);
    for (int r = 0; r < 25; r++) begin
      for (int b = 0; b < 160; b++) begin
        ram[r * 160 + b] = 8'(r);
        modelMem[r * 160 + b] = r;
      end
    end
    applyStimulus(8'h5A, 8'h4E, lc);
    checkOutput("scroll_z_char", int'(ram[3838]), 8'h5A);
    checkOutput("scroll_z_attr", int'(ram[3839]), 8'h4E);
    checkOutput("scroll_row0", int'(ram[0]), 1);
    checkOutput("scroll_busy", int'(busy), 0);
    compareRam("scroll_ram_image");

    // Reset in the middle of a scroll aborts it.
    @(negedge clock);
    modelByte(8'h0A, 8'h33);
    in_data  = 8'h0A;
    attr     = 8'h33;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (300) @(negedge clock);
    checkOutput("midscroll_busy", int'(busy), 1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_mem_we", int'(mem_we), 0);
    checkOutput("abort_cursor_x", int'(cursor_x), 0);
    checkOutput("abort_cursor_y", int'(cursor_y), 0);
    checkOutput("abort_in_ready", int'(in_ready), 1);
    expQ.delete();
    modelX = 0;
    modelY = 0;
    @(negedge clock);
    reset_n = 1'b1;
    wc = writeCount;
    applyStimulus(8'h0C, 8'h07, lc);
    checkOutput("ff_after_abort_count", writeCount - wc, 4000);
    compareRam("ff_after_abort_image");

    // Tab stops (ignored unless the feature is built in).
    for (int i = 0; i < 3; i++) applyStimulus($urandom_range(32, 255), 8'h07, lc);
    applyStimulus(8'h09, 8'h07, lc);
    for (int i = 0; i < 69; i++) applyStimulus($urandom_range(32, 255), 8'h07, lc);
    applyStimulus(8'h09, 8'h07, lc);

    // Random byte stream.
    for (int i = 0; i < 150; i++) applyStimulus(randomByte(), $urandom_range(0, 255), lc);
    compareRam("random_ram_image");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
